// File: rtl/gerenciador_tiros_if.sv
// Signal bundle between the shot manager and the game logic.
// The game logic drives the requests and hits; the manager returns the slot table and the grant pulses.
interface gerenciador_tiros_if #(
  parameter int N_SLOTS = 4
);
  logic                   pausa;
  logic                   reiniciarJogo;
  logic                   req_aliado;
  logic [9:0]             x_aliado;
  logic [9:0]             y_aliado;
  logic                   req_inimigo;
  logic [9:0]             x_inimigo;
  logic [9:0]             y_inimigo;
  logic [N_SLOTS-1:0]     acerto;
  logic                   ack_aliado;
  logic                   ack_inimigo;
  logic [N_SLOTS-1:0]     ativo;
  logic [N_SLOTS-1:0]     aliado;
  logic [10*N_SLOTS-1:0]  x_tiros;
  logic [10*N_SLOTS-1:0]  y_tiros;
  logic                   tick;

  modport master (
    output pausa, reiniciarJogo, req_aliado, x_aliado, y_aliado,
           req_inimigo, x_inimigo, y_inimigo, acerto,
    input  ack_aliado, ack_inimigo, ativo, aliado, x_tiros, y_tiros, tick
  );

  modport slave (
    input  pausa, reiniciarJogo, req_aliado, x_aliado, y_aliado,
           req_inimigo, x_inimigo, y_inimigo, acerto,
    output ack_aliado, ack_inimigo, ativo, aliado, x_tiros, y_tiros, tick
  );
endinterface

// File: rtl/gerenciador_tiros.sv
// Shot slot manager: allocates player/enemy shots into a fixed slot table,
// moves them on every movement tick and frees them on hit or when they leave the screen.
module gerenciador_tiros #(
  parameter int N_SLOTS  = 4,
  parameter int TICK_DIV = 833333,
  parameter int SPEED    = 2,
  parameter int COOLDOWN = 15,
  parameter int Y_MAX    = 480
) (
  input logic               CLOCK_50,
  input logic               reset,
  gerenciador_tiros_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {RODANDO, PAUSADO, LIMPANDO} estado_t;

  typedef struct packed {
    logic       ativo;
    logic       aliado;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  localparam slot_t SLOT_LIVRE = '{ativo: 1'b0, aliado: 1'b0, x: 10'd1000, y: 10'd1000};

  // Reset asserts immediately but releases only after two clean edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  estado_t                   state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CD_W-1:0]           cd_q, cd_d;
  logic                      ptr_q, ptr_d;
  slot_t [N_SLOTS-1:0]       slot_q, slot_d;
  logic                      ack_al_q, ack_al_d;
  logic                      ack_in_q, ack_in_d;
  logic                      tick_q, tick_d;

  logic                      run, tick_ev, found;
  logic                      el_al, el_in, grant_al, grant_in;
  logic [IDX_W-1:0]          free_idx;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cd_d     = cd_q;
    ptr_d    = ptr_q;
    slot_d   = slot_q;
    ack_al_d = 1'b0;
    ack_in_d = 1'b0;
    tick_d   = 1'b0;

    run     = (state_q == RODANDO) && !bus.reiniciarJogo;
    tick_ev = run && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Lowest-index free slot, judged on the registered table only.
    found    = 1'b0;
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slot_q[i].ativo) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end

    el_al    = run && found && bus.req_aliado && (cd_q == '0);
    el_in    = run && found && bus.req_inimigo;
    grant_al = el_al && (!el_in || !ptr_q);
    grant_in = el_in && !grant_al;

    if (bus.reiniciarJogo) begin
      state_d = LIMPANDO;
    end else begin
      case (state_q)
        RODANDO:  if (bus.pausa) state_d = PAUSADO;
        PAUSADO:  if (!bus.pausa) state_d = RODANDO;
        LIMPANDO: state_d = bus.pausa ? PAUSADO : RODANDO;
        default:  state_d = RODANDO;
      endcase
    end

    if (bus.reiniciarJogo || state_q == LIMPANDO) begin
      cnt_d = '0;
      cd_d  = '0;
      ptr_d = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) slot_d[i] = SLOT_LIVRE;
    end else if (run) begin
      if (tick_ev) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (cd_q != '0) cd_d = cd_q - CD_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // A hit beats movement; inactive slots ignore hits.
      for (int i = 0; i < N_SLOTS; i++) begin
        if (slot_q[i].ativo) begin
          if (bus.acerto[i]) begin
            slot_d[i] = SLOT_LIVRE;
          end else if (tick_ev) begin
            if (slot_q[i].aliado) begin
              if (slot_q[i].y < 10'(SPEED)) slot_d[i] = SLOT_LIVRE;
              else                          slot_d[i].y = slot_q[i].y - 10'(SPEED);
            end else begin
              if ({1'b0, slot_q[i].y} + 11'(SPEED) >= 11'(Y_MAX)) slot_d[i] = SLOT_LIVRE;
              else                                              slot_d[i].y = slot_q[i].y + 10'(SPEED);
            end
          end
        end
      end

      // ptr_q = 1 means the player won the last conflict, so the enemy goes next.
      if (el_al && el_in) ptr_d = ~ptr_q;

      if (grant_al) begin
        slot_d[free_idx] = '{ativo: 1'b1, aliado: 1'b1, x: bus.x_aliado, y: bus.y_aliado};
        cd_d             = CD_W'(COOLDOWN);
        ack_al_d         = 1'b1;
      end else if (grant_in) begin
        slot_d[free_idx] = '{ativo: 1'b1, aliado: 1'b0, x: bus.x_inimigo, y: bus.y_inimigo};
        ack_in_d         = 1'b1;
      end
    end
  end

  // NOTE: the slot table is a handful of flops, not a RAM, so it is reset with everything else.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RODANDO;
      cnt_q    <= '0;
      cd_q     <= '0;
      ptr_q    <= 1'b0;
      slot_q   <= {N_SLOTS{SLOT_LIVRE}};
      ack_al_q <= 1'b0;
      ack_in_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cd_q     <= cd_d;
      ptr_q    <= ptr_d;
      slot_q   <= slot_d;
      ack_al_q <= ack_al_d;
      ack_in_q <= ack_in_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.ack_aliado  = ack_al_q;
  assign bus.ack_inimigo = ack_in_q;
  assign bus.tick        = tick_q;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_out
    assign bus.ativo[g]             = slot_q[g].ativo;
    assign bus.aliado[g]            = slot_q[g].aliado;
    assign bus.x_tiros[10*g +: 10]  = slot_q[g].x;
    assign bus.y_tiros[10*g +: 10]  = slot_q[g].y;
  end

endmodule

// File: tb/tb_gerenciador_tiros.sv
// Directed bench for gerenciador_tiros with N_SLOTS=4, TICK_DIV=4, SPEED=2, COOLDOWN=3.
module tb_gerenciador_tiros;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  gerenciador_tiros_if #(.N_SLOTS(4)) bus ();

  gerenciador_tiros #(
    .N_SLOTS (4),
    .TICK_DIV(4),
    .SPEED   (2),
    .COOLDOWN(3),
    .Y_MAX   (480)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 20 * n) begin
      step();
      cyc++;
      if (bus.tick) seen++;
    end
    check("wait_ticks", seen, n);
  endtask

  function automatic logic [9:0] sx(input int i);
    return bus.x_tiros[10*i +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return bus.y_tiros[10*i +: 10];
  endfunction

  logic [39:0] all_1000;
  logic        acc_a, acc_b;
  int          cyc;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    all_1000     = {4{10'd1000}};

    rst_n             = 1'b0;
    bus.pausa         = 1'b0;
    bus.reiniciarJogo = 1'b0;
    bus.req_aliado    = 1'b1;
    bus.x_aliado      = 10'd100;
    bus.y_aliado      = 10'd420;
    bus.req_inimigo   = 1'b0;
    bus.x_inimigo     = 10'd0;
    bus.y_inimigo     = 10'd0;
    bus.acerto        = 4'b0000;

    // Reset state
    repeat (3) step();
    check("rst_ativo", bus.ativo, 4'b0000);
    check("rst_aliado", bus.aliado, 4'b0000);
    check("rst_ack_aliado", bus.ack_aliado, 1'b0);
    check("rst_ack_inimigo", bus.ack_inimigo, 1'b0);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_x_tiros", bus.x_tiros, all_1000);
    check("rst_y_tiros", bus.y_tiros, all_1000);

    rst_n = 1'b1;
    step();
    check("first_cycle_no_ack", bus.ack_aliado, 1'b0);

    // Player shot at (100,420) into slot 0
    cyc = 0;
    while (!bus.ativo[0] && cyc < 10) begin
      step();
      cyc++;
    end
    check("p_ativo", bus.ativo, 4'b0001);
    check("p_aliado", bus.aliado, 4'b0001);
    check("p_x", sx(0), 10'd100);
    check("p_y", sy(0), 10'd420);
    check("p_ack", bus.ack_aliado, 1'b1);
    bus.req_aliado = 1'b0;
    step();
    check("p_ack_drop", bus.ack_aliado, 1'b0);
    wait_ticks(5);
    check("p_y_5ticks", sy(0), 10'd410);

    // Conflict: player first, enemy next cycle
    bus.acerto = 4'b0001;
    step();
    bus.acerto = 4'b0000;
    check("hit_free_ativo", bus.ativo, 4'b0000);
    check("hit_free_y", sy(0), 10'd1000);
    bus.req_aliado  = 1'b1; bus.x_aliado  = 10'd50;  bus.y_aliado  = 10'd300;
    bus.req_inimigo = 1'b1; bus.x_inimigo = 10'd200; bus.y_inimigo = 10'd40;
    step();
    check("c1_ack_al", bus.ack_aliado, 1'b1);
    check("c1_ack_in", bus.ack_inimigo, 1'b0);
    check("c1_ativo", bus.ativo, 4'b0001);
    check("c1_y0", sy(0), 10'd300);
    step();
    check("c2_ack_in", bus.ack_inimigo, 1'b1);
    check("c2_ack_al", bus.ack_aliado, 1'b0);
    check("c2_ativo", bus.ativo, 4'b0011);
    check("c2_aliado", bus.aliado, 4'b0001);
    check("c2_x1", sx(1), 10'd200);
    check("c2_y1", sy(1), 10'd40);
    bus.req_aliado  = 1'b0;
    bus.req_inimigo = 1'b0;
    wait_ticks(3);

    // Second conflict: enemy wins this time
    bus.req_aliado  = 1'b1; bus.x_aliado  = 10'd60; bus.y_aliado  = 10'd350;
    bus.req_inimigo = 1'b1; bus.x_inimigo = 10'd70; bus.y_inimigo = 10'd80;
    step();
    check("c3_ack_in", bus.ack_inimigo, 1'b1);
    check("c3_ack_al", bus.ack_aliado, 1'b0);
    check("c3_ativo", bus.ativo, 4'b0111);
    check("c3_x2", sx(2), 10'd70);
    check("c3_y2", sy(2), 10'd80);
    step();
    check("c4_ack_al", bus.ack_aliado, 1'b1);
    check("c4_ativo", bus.ativo, 4'b1111);
    check("c4_aliado", bus.aliado, 4'b1001);
    check("c4_x3", sx(3), 10'd60);
    check("c4_y3", sy(3), 10'd350);
    bus.req_aliado = 1'b0;

    // Table full: enemy request held, no ack until slot 2 is hit
    bus.x_inimigo = 10'd333;
    bus.y_inimigo = 10'd111;
    acc_a = 1'b0;
    repeat (3) begin
      step();
      acc_a |= bus.ack_inimigo;
    end
    check("full_no_ack", acc_a, 1'b0);
    bus.acerto = 4'b0100;
    step();
    bus.acerto = 4'b0000;
    check("full_hit_ativo", bus.ativo, 4'b1011);
    check("full_hit_y2", sy(2), 10'd1000);
    check("full_hit_no_ack", bus.ack_inimigo, 1'b0);
    step();
    check("refill_ack", bus.ack_inimigo, 1'b1);
    check("refill_ativo", bus.ativo, 4'b1111);
    check("refill_aliado", bus.aliado, 4'b1001);
    check("refill_x2", sx(2), 10'd333);
    check("refill_y2", sy(2), 10'd111);
    bus.req_inimigo = 1'b0;
    step();
    check("refill_ack_drop", bus.ack_inimigo, 1'b0);

    // Enemy at y=476: 478 after first tick, freed on the second
    bus.acerto = 4'b1111;
    step();
    bus.acerto = 4'b0000;
    check("clear_all_hit", bus.ativo, 4'b0000);
    wait_ticks(1);
    bus.req_inimigo = 1'b1; bus.x_inimigo = 10'd5; bus.y_inimigo = 10'd476;
    step();
    bus.req_inimigo = 1'b0;
    check("edge_ack", bus.ack_inimigo, 1'b1);
    check("edge_y_spawn", sy(0), 10'd476);
    repeat (3) step();
    check("edge_tick1", bus.tick, 1'b1);
    check("edge_y478", sy(0), 10'd478);
    acc_a = 1'b0;
    repeat (3) begin
      step();
      acc_a |= bus.tick;
    end
    check("edge_no_tick", acc_a, 1'b0);
    check("edge_still_ativo", bus.ativo, 4'b0001);
    step();
    check("edge_tick2", bus.tick, 1'b1);
    check("edge_freed", bus.ativo, 4'b0000);
    check("edge_x1000", sx(0), 10'd1000);
    check("edge_y1000", sy(0), 10'd1000);

    // Pause for 20 cycles mid-flight
    wait_ticks(1);
    bus.req_inimigo = 1'b1; bus.x_inimigo = 10'd10; bus.y_inimigo = 10'd100;
    step();
    bus.req_inimigo = 1'b0;
    check("pz_spawn_y", sy(0), 10'd100);
    step();
    bus.pausa = 1'b1;
    step();
    check("pz_enter_no_tick", bus.tick, 1'b0);
    bus.req_inimigo = 1'b1; bus.x_inimigo = 10'd7; bus.y_inimigo = 10'd7;
    acc_a = 1'b0;
    acc_b = 1'b0;
    repeat (19) begin
      step();
      acc_a |= bus.tick;
      acc_b |= bus.ack_inimigo;
    end
    check("pz_no_tick", acc_a, 1'b0);
    check("pz_no_ack", acc_b, 1'b0);
    check("pz_ativo", bus.ativo, 4'b0001);
    check("pz_y_frozen", sy(0), 10'd100);
    bus.pausa       = 1'b0;
    bus.req_inimigo = 1'b0;
    step();
    check("pz_resume1_tick", bus.tick, 1'b0);
    check("pz_resume1_y", sy(0), 10'd100);
    step();
    check("pz_resume2_tick", bus.tick, 1'b1);
    check("pz_resume2_y", sy(0), 10'd102);

    // Restart with slots active and player cooldown at 2
    wait_ticks(4);
    bus.req_aliado = 1'b1; bus.x_aliado = 10'd400; bus.y_aliado = 10'd450;
    step();
    bus.req_aliado = 1'b0;
    check("rs_ack_al", bus.ack_aliado, 1'b1);
    check("rs_ativo", bus.ativo, 4'b0011);
    check("rs_aliado", bus.aliado, 4'b0010);
    wait_ticks(1);
    bus.reiniciarJogo = 1'b1;
    bus.req_aliado = 1'b1; bus.x_aliado = 10'd123; bus.y_aliado = 10'd321;
    step();
    bus.reiniciarJogo = 1'b0;
    check("rs_clear_ativo", bus.ativo, 4'b0000);
    check("rs_clear_aliado", bus.aliado, 4'b0000);
    check("rs_clear_x", bus.x_tiros, all_1000);
    check("rs_clear_y", bus.y_tiros, all_1000);
    check("rs_clear_no_ack", bus.ack_aliado, 1'b0);
    step();
    check("rs_limpando_ativo", bus.ativo, 4'b0000);
    check("rs_limpando_no_ack", bus.ack_aliado, 1'b0);
    step();
    bus.req_aliado = 1'b0;
    check("rs_fire_ack", bus.ack_aliado, 1'b1);
    check("rs_fire_ativo", bus.ativo, 4'b0001);
    check("rs_fire_aliado", bus.aliado, 4'b0001);
    check("rs_fire_x", sx(0), 10'd123);
    check("rs_fire_y", sy(0), 10'd321);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
